// File: rtl/vga_timing_rx.sv
// vga_timing_rx: receive-side VGA timing recovery. It samples the active-low
// HSYNC/VSYNC lines and 12-bit RGB on pix_ce, measures line and frame totals,
// locks after two identical frames, and emits pixel coordinates with the
// registered colour.
// Optional build macro VGA_RX_CHECKSUM_EN enables the per-frame RGB checksum
// on frame_sum. Without it, frame_sum is tied to zero.
module vga_timing_rx #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_ce,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic [11:0] vga_rgb,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [11:0] pix_rgb,
  output logic        frame_start,
  output logic [11:0] h_total,
  output logic [10:0] v_total,
  output logic        locked,
  output logic        lock_lost,
  output logic [15:0] frame_sum
);

  localparam logic [11:0] H_LO = 12'(H_BP);
  localparam logic [11:0] H_HI = 12'(H_BP + H_ACTIVE);
  localparam logic [10:0] V_LO = 11'(V_BP);
  localparam logic [10:0] V_HI = 11'(V_BP + V_ACTIVE);

  typedef enum logic [1:0] {HUNT, CHECK, LOCK} state_t;

  logic [1:0]  hs_sync_q, vs_sync_q;
  logic [11:0] rgb_s1_q, rgb_s2_q;
  logic        smp_v_q, hs_smp_q, hs_prv_q, vs_smp_q, vs_prv_q;
  logic [11:0] rgb_smp_q;
  logic [11:0] hpos_q, hpos_d, h_meas, ref_h_q;
  logic [10:0] vline_q, vline_d, v_meas, vprev_q;
  logic        vs_rose_q, bad_q;
  logic        hs_rise, vs_rise, vs_pend, frame_edge, active, sat;
  state_t      state_q;

  // Two-flop synchronizers on every input pin, running every clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_sync_q <= '0;
      vs_sync_q <= '0;
      rgb_s1_q  <= '0;
      rgb_s2_q  <= '0;
    end else begin
      hs_sync_q <= {hs_sync_q[0], vga_hs};
      vs_sync_q <= {vs_sync_q[0], vga_vs};
      rgb_s1_q  <= vga_rgb;
      rgb_s2_q  <= rgb_s1_q;
    end
  end

  // Sample stage: capture the synchronized inputs on pix_ce and keep the previous sample for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      smp_v_q   <= 1'b0;
      hs_smp_q  <= 1'b0;
      hs_prv_q  <= 1'b0;
      vs_smp_q  <= 1'b0;
      vs_prv_q  <= 1'b0;
      rgb_smp_q <= '0;
    end else begin
      smp_v_q <= pix_ce;
      if (pix_ce) begin
        hs_smp_q  <= hs_sync_q[1];
        hs_prv_q  <= hs_smp_q;
        vs_smp_q  <= vs_sync_q[1];
        vs_prv_q  <= vs_smp_q;
        rgb_smp_q <= rgb_s2_q;
      end
    end
  end

  assign hs_rise    = smp_v_q & hs_smp_q & ~hs_prv_q;
  assign vs_rise    = smp_v_q & vs_smp_q & ~vs_prv_q;
  // A VS rise on this sample counts before a coincident HS rise.
  assign vs_pend    = vs_rose_q | vs_rise;
  assign frame_edge = hs_rise & vs_pend;
  assign h_meas     = hpos_q + 12'd1;
  assign v_meas     = vline_q;

  // Next position counters for the current sample and the active-window decode.
  always_comb begin
    hpos_d  = hpos_q;
    vline_d = vline_q;
    if (smp_v_q) begin
      if (hs_rise)
        hpos_d = '0;
      else if (hpos_q != '1)
        hpos_d = hpos_q + 12'd1;
      if (hs_rise) begin
        if (vs_pend)
          vline_d = 11'd1;
        else if (vline_q != '1)
          vline_d = vline_q + 11'd1;
      end
    end
    active = (state_q == LOCK) && (hpos_d >= H_LO) && (hpos_d < H_HI) &&
             (vline_d >= V_LO) && (vline_d < V_HI);
    sat    = smp_v_q && ((hpos_d == '1) || (vline_d == '1));
  end

  // Position counters and line/frame total measurements.
  always_ff @(posedge clk) begin
    if (rst) begin
      hpos_q    <= '0;
      vline_q   <= '0;
      vs_rose_q <= 1'b0;
      h_total   <= '0;
      v_total   <= '0;
    end else if (smp_v_q) begin
      hpos_q    <= hpos_d;
      vline_q   <= vline_d;
      vs_rose_q <= vs_pend & ~frame_edge;
      if (hs_rise)
        h_total <= h_meas;
      if (frame_edge)
        v_total <= v_meas;
    end
  end

  // Lock FSM. A frame is judged on the HS rise that consumes the VS rise,
  // because that is the point at which the frame's line count is known.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HUNT;
      ref_h_q   <= '0;
      vprev_q   <= '0;
      bad_q     <= 1'b0;
      locked    <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      lock_lost <= 1'b0;
      case (state_q)
        HUNT: begin
          if (frame_edge) begin
            state_q <= CHECK;
            ref_h_q <= h_meas;
            vprev_q <= v_meas;
            bad_q   <= 1'b0;
          end
        end
        CHECK: begin
          if (frame_edge) begin
            if (!bad_q && (h_meas == ref_h_q) && (v_meas == vprev_q) &&
                (ref_h_q >= H_HI) && (v_meas >= V_HI)) begin
              state_q <= LOCK;
              locked  <= 1'b1;
            end else begin
              ref_h_q <= h_meas;
              vprev_q <= v_meas;
              bad_q   <= 1'b0;
            end
          end else if ((hs_rise && (h_meas != ref_h_q)) || sat) begin
            bad_q <= 1'b1;
          end
        end
        LOCK: begin
          if ((hs_rise && (h_meas != ref_h_q)) ||
              (frame_edge && (v_meas != vprev_q)) || sat) begin
            state_q   <= HUNT;
            locked    <= 1'b0;
            lock_lost <= 1'b1;
          end
        end
        default: begin
          state_q <= HUNT;
          locked  <= 1'b0;
        end
      endcase
    end
  end

  // Registered pixel outputs; coordinates and colour hold between active samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
      frame_start <= 1'b0;
    end else begin
      pix_valid   <= smp_v_q & active;
      frame_start <= vs_rise;
      if (smp_v_q && active) begin
        pix_x   <= 10'(hpos_d - H_LO);
        pix_y   <= 10'(vline_d - V_LO);
        pix_rgb <= rgb_smp_q;
      end
    end
  end

`ifdef VGA_RX_CHECKSUM_EN
  logic [15:0] acc_q;

  // Frame checksum: sum of emitted pixel colours, latched and cleared at frame_start.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      frame_sum <= '0;
    end else if (frame_start) begin
      frame_sum <= acc_q;
      acc_q     <= pix_valid ? {4'b0, pix_rgb} : '0;
    end else if (pix_valid) begin
      acc_q <= acc_q + {4'b0, pix_rgb};
    end
  end
`else
  assign frame_sum = '0;
`endif

endmodule

// File: tb/tb_vga_timing_rx.sv
// tb_vga_timing_rx: directed bench for vga_timing_rx using a reduced video
// geometry (24x14 total, 16x8 active) with the same porch/sync structure.
// Expected pixels go into a scoreboard queue as they are driven.
module tb_vga_timing_rx;

  localparam int H_ACT = 16;
  localparam int V_ACT = 8;
  localparam int HBP   = 4;
  localparam int VBP   = 3;
  localparam int H_TOT = 24;
  localparam int V_TOT = 14;
  localparam int HS_LO = 18;
  localparam int HS_HI = 20;
  localparam int VS_LO = 9;
  localparam int VS_HI = 11;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [11:0] rgb;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst, pix_ce, vga_hs, vga_vs;
  logic [11:0] vga_rgb;
  logic        pix_valid, frame_start, locked, lock_lost;
  logic [9:0]  pix_x, pix_y;
  logic [11:0] pix_rgb, h_total;
  logic [10:0] v_total;
  logic [15:0] frame_sum;

  int checks = 0;
  int failures = 0;
  int mode, line_no;
  int n_fs, n_ll, n_valid, n_unexp, n_extra;
  logic [9:0]  first_x, first_y, last_x, last_y;
  logic [11:0] first_rgb_obs, first_rgb_exp;
  logic [15:0] sum, exp_sum;
  pix_t        sb[$];

  vga_timing_rx #(
    .H_ACTIVE(H_ACT),
    .V_ACTIVE(V_ACT),
    .H_BP(HBP),
    .V_BP(VBP)
  ) dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_rgb(vga_rgb),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .frame_start(frame_start), .h_total(h_total), .v_total(v_total),
    .locked(locked), .lock_lost(lock_lost), .frame_sum(frame_sum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    pix_t e;
    if (frame_start === 1'b1) n_fs++;
    if (lock_lost === 1'b1) n_ll++;
    if (pix_valid === 1'b1) begin
      n_valid++;
      if (n_valid == 1) begin
        first_x = pix_x;
        first_y = pix_y;
        first_rgb_obs = pix_rgb;
      end
      last_x = pix_x;
      last_y = pix_y;
      if (mode == 1) begin
        if (sb.size() == 0) n_extra++;
        else begin
          e = sb.pop_front();
          chk("sb_pix_x", 32'(pix_x), 32'(e.x));
          chk("sb_pix_y", 32'(pix_y), 32'(e.y));
          chk("sb_pix_rgb", 32'(pix_rgb), 32'(e.rgb));
        end
      end else if (mode == 0) begin
        n_unexp++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic send(input logic hs, input logic vs, input logic [11:0] rgb);
    vga_hs  = hs;
    vga_vs  = vs;
    vga_rgb = rgb;
    pix_ce  = 1'b1;
    tick();
    pix_ce  = 1'b0;
    tick();
  endtask

  task automatic gen_lines(input int n, input int exp_mode, input int long_line, input bit const_rgb);
    int ns, h;
    logic hs, vs;
    logic [11:0] rgb;
    pix_t p;
    mode = exp_mode;
    for (int k = 0; k < n; k++) begin
      ns = H_TOT + ((line_no == long_line) ? 1 : 0);
      for (int s = 0; s < ns; s++) begin
        h   = (line_no == long_line && s > 16) ? s - 1 : s;
        hs  = !(h >= HS_LO && h < HS_HI);
        vs  = !(line_no >= VS_LO && line_no < VS_HI);
        rgb = '0;
        if (h < H_ACT && line_no < V_ACT) begin
          rgb = const_rgb ? 12'h00F : 12'($urandom);
          if (exp_mode == 1) begin
            p.x = 10'(h);
            p.y = 10'(line_no);
            p.rgb = rgb;
            sb.push_back(p);
            sum = sum + {4'b0, rgb};
            if (h == 0 && line_no == 0) first_rgb_exp = rgb;
          end
        end
        send(hs, vs, rgb);
      end
      line_no = (line_no + 1) % V_TOT;
    end
  endtask

  task automatic check_zero(input string ph);
    chk({ph, "_pix_valid"}, 32'(pix_valid), 0);
    chk({ph, "_pix_x"}, 32'(pix_x), 0);
    chk({ph, "_pix_y"}, 32'(pix_y), 0);
    chk({ph, "_pix_rgb"}, 32'(pix_rgb), 0);
    chk({ph, "_frame_start"}, 32'(frame_start), 0);
    chk({ph, "_h_total"}, 32'(h_total), 0);
    chk({ph, "_v_total"}, 32'(v_total), 0);
    chk({ph, "_locked"}, 32'(locked), 0);
    chk({ph, "_lock_lost"}, 32'(lock_lost), 0);
    chk({ph, "_frame_sum"}, 32'(frame_sum), 0);
  endtask

  function automatic logic [15:0] expected_sum(input logic [15:0] s);
`ifdef VGA_RX_CHECKSUM_EN
    return s;
`else
    return 16'(s & 16'h0);
`endif
  endfunction

  task automatic clear_counts();
    n_fs = 0; n_ll = 0; n_valid = 0; n_unexp = 0; n_extra = 0; sum = '0;
  endtask

  initial begin
    mode = 2;
    rst = 1'b1; pix_ce = 1'b0; vga_hs = 1'b1; vga_vs = 1'b1; vga_rgb = '0;
    clear_counts();
    for (int i = 0; i < 3; i++) begin
      pix_ce  = 1'($urandom);
      vga_hs  = 1'($urandom);
      vga_vs  = 1'($urandom);
      vga_rgb = 12'($urandom);
      tick();
    end
    check_zero("rst");
    rst = 1'b0;
    pix_ce = 1'b0;

    // Acquire: start inside VSYNC, lock expected on the third VS rise.
    line_no = VS_LO;
    gen_lines(30, 0, -1, 0);
    chk("acq_locked_before_3rd", 32'(locked), 0);
    chk("acq_frame_starts", 32'(n_fs), 2);
    gen_lines(3, 0, -1, 0);
    chk("acq_locked_after_3rd", 32'(locked), 1);
    chk("acq_h_total", 32'(h_total), 32'(H_TOT));
    chk("acq_v_total", 32'(v_total), 32'(V_TOT));
    chk("acq_lock_lost", 32'(n_ll), 0);
    chk("acq_unexpected_valid", 32'(n_unexp), 0);

    // Locked frame with random colours.
    clear_counts();
    gen_lines(V_TOT, 1, -1, 0);
    exp_sum = sum;
    chk("f1_valid_count", 32'(n_valid), 32'(H_ACT * V_ACT));
    chk("f1_sb_left", 32'(sb.size()), 0);
    chk("f1_sb_extra", 32'(n_extra), 0);
    chk("f1_first_x", 32'(first_x), 0);
    chk("f1_first_y", 32'(first_y), 0);
    chk("f1_first_rgb", 32'(first_rgb_obs), 32'(first_rgb_exp));
    chk("f1_last_x", 32'(last_x), 32'(H_ACT - 1));
    chk("f1_last_y", 32'(last_y), 32'(V_ACT - 1));
    chk("f1_frame_starts", 32'(n_fs), 1);
    chk("f1_frame_sum", 32'(frame_sum), 32'(expected_sum(exp_sum)));
    chk("f1_lock_lost", 32'(n_ll), 0);

    // Locked frame of constant colour 12'h00F.
    clear_counts();
    gen_lines(V_TOT, 1, -1, 1);
    chk("f2_valid_count", 32'(n_valid), 32'(H_ACT * V_ACT));
    chk("f2_frame_sum", 32'(frame_sum), 32'(expected_sum(16'(15 * H_ACT * V_ACT))));
    chk("f2_locked", 32'(locked), 1);

    // Long line (one extra sample) on line 3 breaks lock; relock two VS rises later.
    clear_counts();
    gen_lines(4, 1, 3, 0);
    chk("long_lock_lost", 32'(n_ll), 1);
    chk("long_locked", 32'(locked), 0);
    chk("long_sb_left", 32'(sb.size()), 0);
    gen_lines(10, 0, -1, 0);
    chk("long_locked_check", 32'(locked), 0);
    gen_lines(11, 0, -1, 0);
    chk("long_locked_pre", 32'(locked), 0);
    gen_lines(3, 0, -1, 0);
    chk("long_relocked", 32'(locked), 1);
    chk("long_lock_lost_once", 32'(n_ll), 1);
    chk("long_unexpected_valid", 32'(n_unexp), 0);

    // Reset in the middle of a locked frame.
    clear_counts();
    gen_lines(4, 1, -1, 0);
    chk("mid_sb_left", 32'(sb.size()), 0);
    mode = 2;
    rst = 1'b1;
    tick();
    check_zero("midrst");
    rst = 1'b0;
    gen_lines(10, 0, -1, 0);
    gen_lines(V_TOT, 0, -1, 0);
    gen_lines(11, 0, -1, 0);
    chk("mid_locked_pre", 32'(locked), 0);
    gen_lines(3, 0, -1, 0);
    chk("mid_relocked", 32'(locked), 1);
    chk("mid_lock_lost", 32'(n_ll), 0);
    chk("mid_unexpected_valid", 32'(n_unexp), 0);
    clear_counts();
    gen_lines(V_TOT, 1, -1, 0);
    chk("mid_f_valid_count", 32'(n_valid), 32'(H_ACT * V_ACT));
    chk("mid_f_sb_left", 32'(sb.size()), 0);
    chk("mid_f_sb_extra", 32'(n_extra), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
